// File: rtl/axis_txfifo_lite_v3.sv
// axis_txfifo_lite_v3
// AXI4-Lite programmed transmit FIFO draining onto an AXI4-Stream master.
// A processor pushes words through DATA / DATA_LAST. The block presents them
// on the stream port from a registered output stage. Optional features are
// store-and-forward packet mode, flush, sticky overflow and a level interrupt.
//
// Ports:
//   ACLK, ARESETN          single clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*        AXI-Lite write (AW and W accepted together)
//   s_axi_ar*/r*           AXI-Lite read
//   m_axis_t*              stream output (DATA_W data + tlast)
//   irq                    (IRQ_EN && LEVEL <= THRESH) || OVF
//
// Register map (byte address, word decode on bits [4:2]):
//   0x00 CTRL   [0] ENABLE [1] FLUSH (self-clearing) [2] PKT_MODE [3] IRQ_EN
//   0x04 STATUS [0] EMPTY [1] FULL [2] OVF (W1C) [16+] LEVEL
//   0x08 DATA (WO)   0x0C DATA_LAST (WO)   0x10 THRESH
module axis_txfifo_lite_v3 #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int ADDR_W     = 5
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0]         LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [LW-1:0]         LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [LW-1:0]         LVL_ZERO = {LW{1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_DATA   = 3'd2;
  localparam logic [2:0] A_LAST   = 3'd3;
  localparam logic [2:0] A_THRESH = 3'd4;

  // Storage: {tlast, data} per entry.
  logic [DATA_W:0] mem_q [DEPTH];

  logic                  awready_q, awready_d, bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  enable_q, enable_d, pkt_mode_q, pkt_mode_d;
  logic                  irq_en_q, irq_en_d, flush_pend_q, flush_pend_d;
  logic                  ovf_q, ovf_d;
  logic [LW-1:0]         thresh_q, thresh_d, level_q, level_d, pkt_cnt_q, pkt_cnt_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [DATA_W-1:0]     tdata_q, tdata_d;

  logic [2:0]  wr_idx_s, rd_idx_s;
  logic        wr_en_s, rd_en_s, full_s, empty_s, beat_done_s, flush_do_s;
  logic        push_req_s, push_s, pop_s, eligible_s, pkt_inc_s, pkt_dec_s;
  logic [31:0] status_s, rd_mux_s;
  logic        unused_s;

  assign wr_idx_s    = s_axi_awaddr[4:2];
  assign rd_idx_s    = s_axi_araddr[4:2];
  assign wr_en_s     = awready_q && s_axi_awvalid && s_axi_wvalid;
  assign rd_en_s     = arready_q && s_axi_arvalid;
  assign full_s      = (level_q == LVL_FULL);
  assign empty_s     = (level_q == LVL_ZERO);
  assign beat_done_s = tvalid_q && m_axis_tready;
  // Flush waits until no beat is held in the output register.
  assign flush_do_s  = flush_pend_q && (!tvalid_q || m_axis_tready);
  assign push_req_s  = wr_en_s && ((wr_idx_s == A_DATA) || (wr_idx_s == A_LAST));
  // Fullness uses the pre-cycle level; a push landing on a flush is discarded.
  assign push_s      = push_req_s && !full_s && !flush_do_s;
  assign eligible_s  = enable_q && !empty_s && (!pkt_mode_q || (pkt_cnt_q != LVL_ZERO));
  assign pop_s       = eligible_s && (!tvalid_q || m_axis_tready) && !flush_do_s;
  assign pkt_inc_s   = push_s && (wr_idx_s == A_LAST);
  assign pkt_dec_s   = beat_done_s && tlast_q;
  assign unused_s    = ^{s_axi_wstrb, s_axi_awaddr, s_axi_araddr, s_axi_wdata};

  // Next-state logic for bus channels, control registers, FIFO and stream stage.
  always_comb begin
    awready_d    = s_axi_awvalid && s_axi_wvalid && !bvalid_q && !awready_q;
    arready_d    = s_axi_arvalid && !rvalid_q && !arready_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    rvalid_d     = rvalid_q;
    rdata_d      = rdata_q;
    enable_d     = enable_q;
    pkt_mode_d   = pkt_mode_q;
    irq_en_d     = irq_en_q;
    flush_pend_d = flush_pend_q && !flush_do_s;
    ovf_d        = ovf_q;
    thresh_d     = thresh_q;
    level_d      = level_q;
    pkt_cnt_d    = pkt_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    tvalid_d     = tvalid_q;
    tdata_d      = tdata_q;
    tlast_d      = tlast_q;

    status_s             = 32'h0000_0000;
    status_s[0]          = empty_s;
    status_s[1]          = full_s;
    status_s[2]          = ovf_q;
    status_s[16 +: LW]   = level_q;

    case (rd_idx_s)
      A_CTRL:   rd_mux_s = {28'h000_0000, irq_en_q, pkt_mode_q, 1'b0, enable_q};
      A_STATUS: rd_mux_s = status_s;
      A_THRESH: rd_mux_s = {{(32-LW){1'b0}}, thresh_q};
      default:  rd_mux_s = 32'h0000_0000;
    endcase

    if (wr_en_s) begin
      bvalid_d = 1'b1;
      bresp_d  = (push_req_s && full_s) ? 2'b10 : 2'b00;
    end else if (s_axi_bready) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end

    if (rd_en_s) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux_s;
    end else if (s_axi_rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end

    if (wr_en_s) begin
      case (wr_idx_s)
        A_CTRL: begin
          enable_d     = s_axi_wdata[0];
          flush_pend_d = flush_pend_d | s_axi_wdata[1];
          pkt_mode_d   = s_axi_wdata[2];
          irq_en_d     = s_axi_wdata[3];
        end
        A_STATUS: ovf_d    = ovf_q & ~s_axi_wdata[2];
        A_DATA:   ovf_d    = ovf_q | full_s;
        A_LAST:   ovf_d    = ovf_q | full_s;
        A_THRESH: thresh_d = s_axi_wdata[LW-1:0];
        default:  ovf_d    = ovf_q;
      endcase
    end else begin
      ovf_d = ovf_q;
    end

    if (flush_do_s) begin
      wr_ptr_d  = PTR_ZERO;
      rd_ptr_d  = PTR_ZERO;
      level_d   = LVL_ZERO;
      pkt_cnt_d = LVL_ZERO;
    end else begin
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
      case ({pkt_inc_s, pkt_dec_s})
        2'b10:   pkt_cnt_d = pkt_cnt_q + LVL_ONE;
        2'b01:   pkt_cnt_d = pkt_cnt_q - LVL_ONE;
        default: pkt_cnt_d = pkt_cnt_q;
      endcase
    end

    // Output stage reloads on the handshake cycle to keep 1 beat/cycle.
    if (pop_s) begin
      tvalid_d = 1'b1;
      tdata_d  = mem_q[rd_ptr_q][DATA_W-1:0];
      tlast_d  = mem_q[rd_ptr_q][DATA_W];
    end else if (beat_done_s) begin
      tvalid_d = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_q <= 1'b0;  bvalid_q <= 1'b0;  bresp_q <= 2'b00;
      arready_q <= 1'b0;  rvalid_q <= 1'b0;  rdata_q <= 32'h0000_0000;
      enable_q <= 1'b0;   pkt_mode_q <= 1'b0; irq_en_q <= 1'b0;
      flush_pend_q <= 1'b0; ovf_q <= 1'b0;
      thresh_q <= LVL_ZERO; level_q <= LVL_ZERO; pkt_cnt_q <= LVL_ZERO;
      wr_ptr_q <= PTR_ZERO; rd_ptr_q <= PTR_ZERO;
      tvalid_q <= 1'b0;   tlast_q <= 1'b0;   tdata_q <= {DATA_W{1'b0}};
    end else begin
      awready_q <= awready_d; bvalid_q <= bvalid_d; bresp_q <= bresp_d;
      arready_q <= arready_d; rvalid_q <= rvalid_d; rdata_q <= rdata_d;
      enable_q <= enable_d;   pkt_mode_q <= pkt_mode_d; irq_en_q <= irq_en_d;
      flush_pend_q <= flush_pend_d; ovf_q <= ovf_d;
      thresh_q <= thresh_d;   level_q <= level_d; pkt_cnt_q <= pkt_cnt_d;
      wr_ptr_q <= wr_ptr_d;   rd_ptr_q <= rd_ptr_d;
      tvalid_q <= tvalid_d;   tlast_q <= tlast_d; tdata_q <= tdata_d;
    end
  end

  // FIFO storage write port; contents are don't-care while the level is zero.
  always_ff @(posedge ACLK) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {(wr_idx_s == A_LAST), s_axi_wdata[DATA_W-1:0]};
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign irq           = (irq_en_q && (level_q <= thresh_q)) || ovf_q;

endmodule

// File: tb/tb_axis_txfifo_lite_v3.sv
module tb_axis_txfifo_lite_v3;
  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [4:0]  s_axi_awaddr = 5'h00;
  logic        s_axi_awvalid = 1'b0, s_axi_awready;
  logic [31:0] s_axi_wdata = 32'h0;
  logic [3:0]  s_axi_wstrb = 4'hF;
  logic        s_axi_wvalid = 1'b0, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready = 1'b0;
  logic [4:0]  s_axi_araddr = 5'h00;
  logic        s_axi_arvalid = 1'b0, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [32:0] sb[$];
  int cyc = 0, beat_cnt = 0, first_cyc = 0, last_cyc = 0;
  logic stall = 1'b0, stall_last = 1'b0;
  logic [31:0] stall_data = 32'h0;

  axis_txfifo_lite_v3 #(.DATA_W(32), .DEPTH_LOG2(4), .ADDR_W(5)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int n;
    tick();
    s_axi_awaddr = addr; s_axi_wdata = data;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!(s_axi_awready && s_axi_wready) && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk1("aw_accept", s_axi_awready && s_axi_wready, 1'b1);
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin
      tick();
      n++;
    end
    chk1("b_valid", s_axi_bvalid, 1'b1);
    resp = s_axi_bresp;
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [4:0] addr, input logic [31:0] data,
                    input logic [1:0] exp_resp);
    logic [1:0] resp;
    axi_write(addr, data, resp);
    chk(tag, {30'h0, resp}, {30'h0, exp_resp});
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    int n;
    tick();
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!s_axi_arready && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk1("ar_accept", s_axi_arready, 1'b1);
    tick();
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin
      tick();
      n++;
    end
    chk1("r_valid", s_axi_rvalid, 1'b1);
    chk(tag, s_axi_rdata, exp);
    tick();
    s_axi_rready = 1'b0;
  endtask

  task automatic push(input logic last, input logic [31:0] data);
    sb.push_back({last, data});
    wr(last ? "push_last_resp" : "push_resp", last ? 5'h0C : 5'h08, data, 2'b00);
  endtask

  task automatic wait_drain(input int budget, input logic rnd);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      if (rnd) m_axis_tready = 1'($urandom_range(1, 0));
      n++;
    end
    chk("drain", sb.size(), 32'd0);
    m_axis_tready = 1'b1;
  endtask

  task automatic pulse_ready();
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
  endtask

  // Stream monitor: scoreboard compare on handshakes, stability while stalled.
  always @(negedge ACLK) begin
    logic [32:0] exp;
    cyc++;
    if (!ARESETN) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk1("hold_valid", m_axis_tvalid, 1'b1);
        chk("hold_data", m_axis_tdata, stall_data);
        chk1("hold_last", m_axis_tlast, stall_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        chk1("beat_expected", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          exp = sb.pop_front();
          chk("tdata", m_axis_tdata, exp[31:0]);
          chk1("tlast", m_axis_tlast, exp[32]);
        end
        beat_cnt++;
        if (beat_cnt == 1) first_cyc = cyc;
        last_cyc = cyc;
      end
      stall = m_axis_tvalid && !m_axis_tready;
      stall_data = m_axis_tdata;
      stall_last = m_axis_tlast;
    end
  end

  initial begin
    repeat (3) @(posedge ACLK);
    #1;
    chk1("rst_tvalid", m_axis_tvalid, 1'b0);
    chk1("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tdata", m_axis_tdata, 32'h0);
    chk1("rst_irq", irq, 1'b0);
    chk1("rst_bvalid", s_axi_bvalid, 1'b0);
    chk1("rst_rvalid", s_axi_rvalid, 1'b0);
    ARESETN = 1'b1;
    rd("status_reset", 5'h04, 32'h0000_0001);
    rd("ctrl_reset", 5'h00, 32'h0000_0000);

    // Fill with ENABLE=0, then overflow.
    for (int i = 1; i <= 16; i++) push(1'b0, 32'(i));
    rd("status_full", 5'h04, 32'h0010_0002);
    wr("ovf_resp", 5'h08, 32'h0000_0011, 2'b10);
    rd("status_ovf", 5'h04, 32'h0010_0006);
    chk1("irq_ovf", irq, 1'b1);
    wr("w1c_resp", 5'h04, 32'h0000_0004, 2'b00);
    chk1("irq_w1c", irq, 1'b0);
    rd("status_w1c", 5'h04, 32'h0010_0002);

    // Drain at full rate.
    beat_cnt = 0;
    wr("ctrl_en", 5'h00, 32'h0000_0001, 2'b00);
    wait_drain(100, 1'b0);
    chk("burst_beats", beat_cnt, 32'd16);
    chk("burst_span", last_cyc - first_cyc, 32'd15);
    tick();
    chk1("burst_idle", m_axis_tvalid, 1'b0);
    rd("status_drained", 5'h04, 32'h0000_0001);

    // Packet mode: nothing leaves until the packet is complete.
    wr("ctrl_pkt", 5'h00, 32'h0000_0005, 2'b00);
    push(1'b0, 32'h0000_000A);
    push(1'b0, 32'h0000_000B);
    repeat (4) tick();
    chk1("pkt_gated", m_axis_tvalid, 1'b0);
    rd("status_pkt2", 5'h04, 32'h0002_0000);
    push(1'b1, 32'h0000_000C);
    wait_drain(200, 1'b1);
    rd("status_pkt_done", 5'h04, 32'h0000_0001);

    // Threshold interrupt while filling with ENABLE=0.
    wr("ctrl_irq", 5'h00, 32'h0000_0008, 2'b00);
    wr("thresh_wr", 5'h10, 32'h0000_0002, 2'b00);
    rd("thresh_rd", 5'h10, 32'h0000_0002);
    chk1("irq_lvl0", irq, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      push(1'b0, 32'h50 + 32'(k));
      chk1("irq_fill", irq, k <= 2);
    end
    rd("status_lvl5", 5'h04, 32'h0005_0000);

    // Drain one beat at a time; irq rises once LEVEL reaches THRESH.
    m_axis_tready = 1'b0;
    wr("ctrl_en_irq", 5'h00, 32'h0000_0009, 2'b00);
    repeat (3) tick();
    chk1("stalled_valid", m_axis_tvalid, 1'b1);
    rd("status_lvl4", 5'h04, 32'h0004_0000);
    chk1("irq_lvl4", irq, 1'b0);
    pulse_ready();
    chk1("irq_lvl3", irq, 1'b0);
    pulse_ready();
    chk1("irq_lvl2", irq, 1'b1);
    rd("status_lvl2", 5'h04, 32'h0002_0000);

    // Flush while a beat is stalled: waits for that handshake.
    wr("ctrl_flush", 5'h00, 32'h0000_000B, 2'b00);
    rd("ctrl_flush_rd", 5'h00, 32'h0000_0009);
    rd("status_flush_pend", 5'h04, 32'h0002_0000);
    chk1("flush_pend_valid", m_axis_tvalid, 1'b1);
    pulse_ready();
    sb.delete();
    repeat (3) tick();
    chk1("flush_idle", m_axis_tvalid, 1'b0);
    rd("status_flushed", 5'h04, 32'h0000_0001);
    chk1("irq_flushed", irq, 1'b1);

    // Unmapped / write-only reads and unmapped write.
    rd("rd_unmapped", 5'h14, 32'h0000_0000);
    rd("rd_data_wo", 5'h08, 32'h0000_0000);
    wr("wr_unmapped", 5'h14, 32'h0000_FFFF, 2'b00);

    // FIFO still works after the flush reset its pointers.
    m_axis_tready = 1'b1;
    push(1'b1, 32'h0000_0077);
    wait_drain(50, 1'b0);

    // Asynchronous reset abandons an in-flight beat.
    m_axis_tready = 1'b0;
    push(1'b0, 32'h0000_0099);
    repeat (3) tick();
    chk1("pre_reset_valid", m_axis_tvalid, 1'b1);
    ARESETN = 1'b0;
    #1;
    chk1("mid_reset_valid", m_axis_tvalid, 1'b0);
    chk1("mid_reset_irq", irq, 1'b0);
    sb.delete();
    tick();
    ARESETN = 1'b1;
    m_axis_tready = 1'b1;
    rd("status_after_rst", 5'h04, 32'h0000_0001);
    rd("ctrl_after_rst", 5'h00, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
